// File: rtl/rv32i_rib_top.sv
// rv32i_rib_top: single-cycle RV32I subset core (R/I ALU, conditional branches) with debug taps.
module rv32i_rib_top #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "imem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  flags,
  output logic [31:0] PCNext,
  output logic [31:0] PC,
  output logic [31:0] PCplus4,
  output logic [31:0] PCTarget,
  output logic [31:0] instr,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] result,
  output logic [31:0] alu_src_out,
  output logic [31:0] immext
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] x [0:31];
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_b, alu, bx;
  logic [32:0] sum;
  logic [4:0]  sh;
  logic signed [31:0] sra_v;
  logic is_r, is_i, is_b, is_jal, is_jalr, r_ok, i_ok, b_ok;
  logic regwrite, sub, arith, taken;
  assign instr  = imem[PC[AW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign rd1 = (rs1 == 5'd0) ? 32'd0 : x[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : x[rs2];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign is_r = opcode == 7'b0110011;
  assign is_i = opcode == 7'b0010011;
  assign is_b = opcode == 7'b1100011;
  assign r_ok = is_r && (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
  assign i_ok = is_i && (funct3 == 3'd1 ? funct7 == 7'h00 :
                         funct3 == 3'd5 ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1);
  assign b_ok = is_b && funct3 != 3'd2 && funct3 != 3'd3;
`ifdef RV32I_JAL_EN
  logic [31:0] imm_j;
  assign imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign is_jal  = opcode == 7'b1101111;
  assign is_jalr = opcode == 7'b1100111;
`else
  assign is_jal  = 1'b0;
  assign is_jalr = 1'b0;
`endif
  assign regwrite = r_ok || i_ok || is_jal || is_jalr;
  always_comb begin
    immext = 32'd0;
    if (i_ok) immext = imm_i;
    if (b_ok) immext = imm_b;
`ifdef RV32I_JAL_EN
    if (is_jalr) immext = imm_i;
    if (is_jal) immext = imm_j;
`endif
  end
  assign alu_src_out = is_i ? immext : rd2;
  assign PCplus4     = PC + 32'd4;
  assign PCTarget    = PC + immext;
  assign sub   = is_b || (is_r && funct3 == 3'd0 && funct7[5]);
  assign arith = is_b || funct3 == 3'd0;
  assign bx    = sub ? ~alu_src_out : alu_src_out;
  assign sum   = {1'b0, rd1} + {1'b0, bx} + {32'd0, sub};
  assign sh    = alu_src_out[4:0];
  assign sra_v = $signed(rd1) >>> sh;
  always_comb begin
    alu = sum[31:0];
    if (!is_b) begin
      case (funct3)
        3'd1:    alu = rd1 << sh;
        3'd2:    alu = {31'd0, $signed(rd1) < $signed(alu_src_out)};
        3'd3:    alu = {31'd0, rd1 < alu_src_out};
        3'd4:    alu = rd1 ^ alu_src_out;
        3'd5:    alu = funct7[5] ? sra_v : rd1 >> sh;
        3'd6:    alu = rd1 | alu_src_out;
        3'd7:    alu = rd1 & alu_src_out;
        default: alu = sum[31:0];
      endcase
    end
  end
  assign flags[3] = alu[31];
  assign flags[2] = alu == 32'd0;
  assign flags[1] = arith && sum[32];
  assign flags[0] = arith && (rd1[31] == bx[31]) && (sum[31] != rd1[31]);
  assign result = (is_jal || is_jalr) ? PCplus4 : alu;
  always_comb begin
    case (funct3)
      3'd0:    taken = flags[2];
      3'd1:    taken = !flags[2];
      3'd4:    taken = flags[3] ^ flags[0];
      3'd5:    taken = !(flags[3] ^ flags[0]);
      3'd6:    taken = !flags[1];
      3'd7:    taken = flags[1];
      default: taken = 1'b0;
    endcase
  end
  always_comb begin
    PCNext = PCplus4;
    if (b_ok && taken) PCNext = PCTarget;
    if (is_jal) PCNext = PCTarget;
    if (is_jalr) PCNext = (rd1 + immext) & ~32'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= RESET_PC;
      for (int i = 0; i < 32; i++) x[i] <= 32'd0;
    end else begin
      PC <= PCNext;
      if (regwrite && rd != 5'd0) x[rd] <= result;
    end
  end
endmodule

// File: tb/tb_rv32i_rib_top.sv
// tb_rv32i_rib_top: random instruction stream poked into the ROM ahead of the PC,
// checked against an architectural model through an expectation queue.
module tb_rv32i_rib_top;
    logic        clk, reset;
    logic [3:0]  flags;
    logic [31:0] PCNext, PC, PCplus4, PCTarget, instr, rd1, rd2, result, alu_src_out, immext;

    rv32i_rib_top #(.IMEM_FILE("")) dut (
        .clk(clk), .reset(reset), .flags(flags), .PCNext(PCNext), .PC(PC), .PCplus4(PCplus4),
        .PCTarget(PCTarget), .instr(instr), .rd1(rd1), .rd2(rd2), .result(result),
        .alu_src_out(alu_src_out), .immext(immext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, ins, rd1, rd2, res, src, imm, pcn;
        logic [3:0]  fl;
        logic        cr, cf, cs;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mreg [0:31];
    logic [31:0] mpc;
    int          n_chk = 0, n_fail = 0;
    bit          done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        logic   c, v;
        longint s;
        c = 1'b0;
        v = 1'b0;
        case (f3)
            3'd0: begin
                if (alt) begin
                    r = a - b;
                    c = a >= b;
                    s = longint'($signed(a)) - longint'($signed(b));
                end else begin
                    r = a + b;
                    c = (a + b) < a;
                    s = longint'($signed(a)) + longint'($signed(b));
                end
                v = s != longint'($signed(r));
            end
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        f = {r[31], r == 32'd0, c, v};
    endfunction

    task automatic issue(input logic [31:0] ins);
        exp_t        e;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a, b, ii, bi, ji;
        logic        wr, tk;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
        a  = mreg[ins[19:15]];
        b  = mreg[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ji = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        e.pc = mpc; e.ins = ins; e.rd1 = a; e.rd2 = b; e.imm = 0; e.res = 0; e.src = b;
        e.fl = 0; e.pcn = mpc + 4; e.cr = 0; e.cf = 0; e.cs = 0;
        wr = 0; tk = 0;
        case (op)
            7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                ref_alu(f3, f7[5], a, b, e.res, e.fl);
                {e.cr, e.cf, e.cs} = 3'b111;
                wr = 1;
            end
            7'b0010011: if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
                e.imm = ii; e.src = ii;
                ref_alu(f3, f3 == 3'd5 && f7[5], a, ii, e.res, e.fl);
                {e.cr, e.cf, e.cs} = 3'b111;
                wr = 1;
            end
            7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) begin
                e.imm = bi;
                ref_alu(3'd0, 1'b1, a, b, e.res, e.fl);
                case (f3)
                    3'd0: tk = a == b;
                    3'd1: tk = a != b;
                    3'd4: tk = $signed(a) < $signed(b);
                    3'd5: tk = $signed(a) >= $signed(b);
                    3'd6: tk = a < b;
                    default: tk = a >= b;
                endcase
                if (tk) e.pcn = mpc + bi;
                {e.cr, e.cf, e.cs} = 3'b111;
            end
`ifdef RV32I_JAL_EN
            7'b1101111: begin
                e.imm = ji; e.res = mpc + 4; e.cr = 1; e.pcn = mpc + ji; wr = 1;
            end
            7'b1100111: begin
                e.imm = ii; e.res = mpc + 4; e.cr = 1; e.pcn = (a + ii) & ~32'd1; wr = 1;
            end
`endif
            default: ;
        endcase
        if (ji == 32'hDEAD_BEEF) e.cr = 0;
        dut.imem[mpc[9:2]] = ins;
        q.push_back(e);
        if (wr && rd != 5'd0) mreg[rd] = e.res;
        mpc = e.pcn;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dut.imem[mpc[9:2]] = 32'h07B0_0093;
        @(negedge clk);
        reset = 1'b0;
        mpc = 32'd0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] imm;
        logic [12:0] bo;
        logic [31:0] w;
        int          k;
        k   = $urandom_range(0, 9);
        f3  = 3'($urandom);
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        bo  = 13'($urandom);
        w   = $urandom;
        case (k)
            0, 1, 2: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                if ($urandom_range(0, 15) == 0) f7 = 7'($urandom);
                return {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            3, 4, 5: begin
                if ($urandom_range(0, 15) != 0) begin
                    if (f3 == 3'd1) imm[11:5] = 7'h00;
                    if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
                end
                return {imm, rs1, f3, rd, 7'b0010011};
            end
            6, 7: return {bo[12], bo[10:5], rs2, rs1, f3, bo[4:1], bo[11], 7'b1100011};
            8:    return w;
            default: return {w[31:7], $urandom_range(0, 1) == 1 ? 7'b1101111 : 7'b1100111};
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc", PC, e.pc);
                check("instr", instr, e.ins);
                check("pcplus4", PCplus4, e.pc + 32'd4);
                check("pctarget", PCTarget, e.pc + e.imm);
                check("rd1", rd1, e.rd1);
                check("rd2", rd2, e.rd2);
                check("immext", immext, e.imm);
                check("pcnext", PCNext, e.pcn);
                if (e.cr) check("result", result, e.res);
                if (e.cf) check("flags", {28'd0, flags}, {28'd0, e.fl});
                if (e.cs) check("alu_src", alu_src_out, e.src);
            end
        end
    end

    initial begin
        logic [31:0] dir [0:11];
        dir = '{32'h0050_0093, 32'h0050_0113, 32'h4020_81B3, 32'h0020_8233,
                32'h0020_8463, 32'h0070_0013, 32'h0000_0013, 32'hFFF0_0093,
                32'h0010_6463, 32'h0010_4463, 32'h4040_D293, 32'h0020_8463};
        reset = 1'b1;
        mpc = 32'd0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) issue(32'h0070_0013);
            else        issue(dir[i]);
        end
        for (int i = 0; i < 400; i++) begin
            if (i == 150 || i == 300) do_reset();
            issue(rand_ins());
        end
        done = 1;
    end

    initial begin
        int c;
        c = 0;
        while (!(done && q.size() == 0) && c < 5000) begin
            @(posedge clk);
            c++;
        end
        if (!(done && q.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d pending, expected 0", q.size());
        end
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
